// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four one-entry holding registers feed one registered
// broadcast port. With CDB_ROUND_ROBIN_EN defined the grant rotates from the
// last granted source; without it, source 0 has the highest fixed priority.
module cdb_arbiter #(
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [3:0]              src_valid,
  input  logic [4*TAG_WIDTH-1:0]  src_tag,
  input  logic [4*DATA_WIDTH-1:0] src_data,
  output logic [3:0]              src_ready,
  output logic                    cdb_valid,
  output logic [TAG_WIDTH-1:0]    cdb_tag,
  output logic [DATA_WIDTH-1:0]   cdb_data,
  output logic [1:0]              cdb_src
);

  logic [3:0]            hold_v_q, hold_v_d;
  logic [TAG_WIDTH-1:0]  hold_tag_q  [4];
  logic [TAG_WIDTH-1:0]  hold_tag_d  [4];
  logic [DATA_WIDTH-1:0] hold_data_q [4];
  logic [DATA_WIDTH-1:0] hold_data_d [4];

  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]            cdb_src_q, cdb_src_d;

  logic       grant_any;
  logic [1:0] grant_idx;
  logic [3:0] grant;
  logic [3:0] handshake;

`ifdef CDB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  // Round-robin pick: first pending entry after the last granted index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    // Descending walk so the nearest candidate (smallest offset) is the last write.
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (hold_v_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (flush) grant_any = 1'b0;
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end
`else
  // Fixed-priority pick: lowest pending index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hold_v_q[i]) begin
        grant_any = 1'b1;
        grant_idx = 2'(i);
      end
    end
    if (flush) grant_any = 1'b0;
    grant = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  end
`endif

  // Ready depends only on registered state; a granted entry frees its slot this cycle.
  always_comb begin
    if (reset) src_ready = 4'b1111;
    else       src_ready = (~hold_v_q | grant) & {4{~flush}};
    handshake = src_valid & src_ready & {4{~reset}};
  end

  // Next-state for holding registers, broadcast port and pointer.
  always_comb begin
    hold_v_d    = hold_v_q & ~grant;
    hold_tag_d  = hold_tag_q;
    hold_data_d = hold_data_q;
    for (int i = 0; i < 4; i++) begin
      if (handshake[i]) begin
        hold_v_d[i]    = 1'b1;
        hold_tag_d[i]  = src_tag[i*TAG_WIDTH +: TAG_WIDTH];
        hold_data_d[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (flush) hold_v_d = 4'b0000;

    cdb_valid_d = grant_any;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (grant_any) begin
      cdb_tag_d  = hold_tag_q[grant_idx];
      cdb_data_d = hold_data_q[grant_idx];
      cdb_src_d  = grant_idx;
    end
`ifdef CDB_ROUND_ROBIN_EN
    ptr_d = grant_any ? grant_idx : ptr_q;
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_v_q    <= 4'b0000;
      hold_tag_q  <= '{default: '0};
      hold_data_q <= '{default: '0};
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 2'd0;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q       <= 2'd3;
`endif
    end else begin
      hold_v_q    <= hold_v_d;
      hold_tag_q  <= hold_tag_d;
      hold_data_q <= hold_data_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
`ifdef CDB_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, all checked
// against a queue-of-pending-results model built from the arbitration rules.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset, flush;
  logic [3:0]   src_valid;
  logic [23:0]  src_tag;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;

  int total = 0;
  int bad   = 0;

  cdb_arbiter #(.TAG_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  // Reference model: one pending slot per source plus the broadcast register.
  bit          m_v    [4];
  logic [5:0]  m_tag  [4];
  logic [31:0] m_data [4];
  int          m_last = 3;
  logic        m_cv;
  logic [5:0]  m_ctag;
  logic [31:0] m_cdata;
  logic [1:0]  m_csrc;

  function automatic int pick();
`ifdef CDB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++)
      if (m_v[(m_last + k) % 4]) return (m_last + k) % 4;
`else
    for (int i = 0; i < 4; i++)
      if (m_v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit fl, input logic [3:0] v,
                       input logic [23:0] tg, input logic [127:0] dt);
    logic [3:0] er;
    int g;
    @(negedge clk);
    reset = rst; flush = fl; src_valid = v; src_tag = tg; src_data = dt;
    g = pick();
    for (int i = 0; i < 4; i++) er[i] = rst ? 1'b1 : ((!m_v[i] || g == i) && !fl);
    #1 chk("src_ready", {60'd0, src_ready}, {60'd0, er});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      m_cv = 0; m_ctag = 0; m_cdata = 0; m_csrc = 0; m_last = 3;
    end else if (fl) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      m_cv = 0;
    end else begin
      m_cv = (g >= 0);
      if (g >= 0) begin
        m_ctag = m_tag[g]; m_cdata = m_data[g]; m_csrc = 2'(g);
        m_last = g; m_v[g] = 0;
      end
      for (int i = 0; i < 4; i++)
        if (v[i] && er[i]) begin
          m_v[i] = 1; m_tag[i] = tg[i*6 +: 6]; m_data[i] = dt[i*32 +: 32];
        end
    end
    #1;
    chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_cv});
    chk("cdb_tag",   {58'd0, cdb_tag},   {58'd0, m_ctag});
    chk("cdb_data",  {32'd0, cdb_data},  {32'd0, m_cdata});
    chk("cdb_src",   {62'd0, cdb_src},   {62'd0, m_csrc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 4'b0000, 24'd0, 128'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
    m_cv = 0; m_ctag = 0; m_cdata = 0; m_csrc = 0;
    for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_tag[i] = 0; m_data[i] = 0; end

    // Reset state.
    cycle(1, 0, 4'b0000, 24'd0, 128'd0);
    cycle(1, 0, 4'b1111, 24'hFFFFFF, {4{32'hDEAD}});
    chk("rst_valid", {63'd0, cdb_valid}, 64'd0);

    // Single result from source 0 appears exactly two cycles later.
    cycle(0, 0, 4'b0001, {18'd0, 6'h05}, {96'd0, 32'hA5});
    chk("lat_k1_valid", {63'd0, cdb_valid}, 64'd0);
    idle(1);
    chk("lat_k2_valid", {63'd0, cdb_valid}, 64'd1);
    chk("lat_k2_tag", {58'd0, cdb_tag}, 64'h05);
    chk("lat_k2_data", {32'd0, cdb_data}, 64'hA5);
    idle(1);
    chk("lat_k3_valid", {63'd0, cdb_valid}, 64'd0);
    chk("lat_k3_tag_kept", {58'd0, cdb_tag}, 64'h05);

    // All four loaded together drain in order 10..13.
    cycle(0, 0, 4'b1111, {6'h13, 6'h12, 6'h11, 6'h10}, {32'd13, 32'd12, 32'd11, 32'd10});
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("drain_tag", {58'd0, cdb_tag}, 64'h10 + 64'(i));
    end
    idle(2);

    // Source 0 refilled every cycle while source 3 holds 3F.
    cycle(0, 0, 4'b1001, {6'h3F, 12'd0, 6'h01}, {32'h3F3F, 64'd0, 32'd1});
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 4'b0001, {18'd0, 6'(i + 2)}, {96'd0, 32'(i + 2)});
    idle(3);

    // Flush with entries pending in sources 1 and 3; flush-cycle valids ignored.
    cycle(0, 0, 4'b1010, {6'h33, 6'h00, 6'h31, 6'h00}, {32'h33, 32'h0, 32'h31, 32'h0});
    cycle(0, 1, 4'b1111, {6'h21, 6'h22, 6'h23, 6'h24}, {4{32'h77}});
    chk("flush_valid", {63'd0, cdb_valid}, 64'd0);
    idle(3);

    // Source 2 granted and refilled with 2A in the same cycle.
    cycle(0, 0, 4'b0100, {6'h00, 6'h29, 12'd0}, {32'd0, 32'h29, 64'd0});
    cycle(0, 0, 4'b0100, {6'h00, 6'h2A, 12'd0}, {32'd0, 32'h2A, 64'd0});
    idle(1);
    chk("refill_tag", {58'd0, cdb_tag}, 64'h2A);
    idle(1);

    // Reset together with flush while entries are pending.
    cycle(0, 0, 4'b1111, {6'h0D, 6'h0C, 6'h0B, 6'h0A}, {4{32'h55}});
    cycle(1, 1, 4'b0000, 24'd0, 128'd0);
    chk("rstfl_tag", {58'd0, cdb_tag}, 64'd0);
    cycle(0, 0, 4'b1100, {6'h1D, 6'h1C, 12'd0}, {32'h1D, 32'h1C, 64'd0});
    chk("post_rst_valid", {63'd0, cdb_valid}, 64'd0);
    cycle(0, 0, 4'b0001, {18'd0, 6'h1A}, {96'd0, 32'h1A});
    idle(5);

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0), 4'($urandom),
            24'($urandom), {$urandom, $urandom, $urandom, $urandom});
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
